fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Shares one synchronous FIFO's write port among NUM_REQ requesters using round-robin arbitration.
- Provides a single read port to the downstream consumer.
- Contains the FIFO storage, read/write pointers, an occupancy counter and the arbitration state.
- Sits between multiple producer blocks and one byte-stream consumer in the memory subsystem.

Parameters:
- NUM_REQ, 4, number of write requesters (2..8).
- DATA_W, 8, data width in bits.
- DEPTH, 16, FIFO entries; must be a power of 2.
- ADDR_W, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_data  input  NUM_REQ*DATA_W  packed write data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot accept; a write occurs for requester i when req_valid[i] && req_ready[i].
- rd_en  input  1  pop request from consumer.
- rd_data  output  DATA_W  registered read data.
- rd_valid  output  1  one-cycle pulse; rd_data is valid for the pop issued on the previous cycle.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- grant_id  output  $clog2(NUM_REQ)  index of the requester accepted this cycle; valid only when |req_ready.

Behaviour:
- Reset (rst_n low, asynchronous):
  - w_ptr = 0, r_ptr = 0, count = 0.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
  - rd_data = 0, rd_valid = 0.
  - Storage contents are don't-care.
- Arbitration (combinational):
  - Search req_valid starting at last_grant+1 mod NUM_REQ; the first set bit wins.
  - req_ready is the one-hot of the winner, asserted only when !full; all zeros when full or when no request is pending.
  - grant_id is the winner's index.
- Write: on an accepted write, mem[w_ptr] <= winner's data, w_ptr <= w_ptr+1 (wraps mod DEPTH), last_grant <= winner.
- last_grant changes only on an accepted write.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 accepted writes.
- Read:
  - Pop when rd_en && !empty: rd_data <= mem[r_ptr], r_ptr <= r_ptr+1 (wraps), rd_valid <= 1 on the next cycle.
  - rd_en while empty is ignored: rd_valid = 0, rd_data holds its last value.
- Simultaneous accepted write and pop: both proceed and count is unchanged.
  - When empty, the pop is refused even if a write is accepted in the same cycle; there is no write-to-read bypass.
- Full: no write is accepted even if a pop occurs in the same cycle; the entry frees on the following cycle.
- Count: +1 on write only, -1 on pop only, unchanged on both or neither.
  - full and empty are decoded from count, so full and empty are never true together.
- Latency:
  - Write to first poppable: 1 cycle after the accept edge, i.e. empty deasserts on the next cycle.
  - Pop to data: 1 cycle.
- Requester rules:
  - A requester may drop req_valid without being granted; no state is kept per requester.
  - req_data must be stable only in the accept cycle.
- Reset mid-operation: all pointers and the count clear immediately; in-flight data is lost and rd_valid drops asynchronously.

Decomposition:
- Package fifo_arb_pkg: DATA_W, DEPTH and NUM_REQ defaults, a helper function for the index width, and a typedef for the data word.
- Sub-module rr_arbiter (parameter N):
  - inputs: req[N], last_grant, enable.
  - outputs: one-hot gnt[N], gnt_id.
  - Purely combinational; last_grant is held in the parent.
- FIFO storage and pointers remain in fifo_wr_arbiter.

Test Plan:
- Reset, then req_valid = 4'b1111 held with rd_en = 0 -> grant_id sequence 0,1,2,3,0,1,...; full after 16 accepts, count = 16, req_ready = 0 thereafter.
- Requesters 1 and 3 request, data 8'hA1 and 8'hB3 alternating; then drain -> rd_data order A1,B3,A1,B3; rd_valid pulses one cycle after each rd_en; empty after the last pop.
- FIFO full (count = 16), rd_en = 1 and req_valid[0] = 1 in the same cycle -> pop occurs, no write accepted, count = 15; the write is accepted on the next cycle and count returns to 16.
- count = 5, one accepted write plus one pop in the same cycle -> count stays 5; pointers each advance by 1. Run 40 such cycles to exercise pointer wrap with no data corruption.
- Empty, rd_en = 1 with a simultaneous write of 8'h55 -> rd_valid = 0, count = 1; pop on the next cycle -> rd_data = 8'h55.
- rst_n asserted low at count = 9 mid-stream -> count = 0, empty = 1, rd_valid = 0 with no clock edge; after release, requester 0 wins the first grant.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared defaults, index-width helper and data word type for the
// round-robin write-arbitrated FIFO.
package fifo_arb_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned DEPTH_DEF   = 16;

  typedef logic [DATA_W_DEF-1:0] data_t;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting one past
// last_grant; the grant is suppressed (but gnt_id still shown) when !enable.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned ID_W = idx_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_grant,
  input  logic            enable,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic        found;
  int unsigned idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (int'(last_grant) + i) % N;
      if (!found && req[ID_W'(idx)]) begin
        found  = 1'b1;
        gnt_id = ID_W'(idx);
      end
    end
    if (enable && found) gnt[gnt_id] = 1'b1;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Synchronous FIFO whose single write port is shared round-robin among
// NUM_REQ producers; one registered read port for the consumer.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned ADDR_W  = $clog2(DEPTH),
  localparam int unsigned ID_W   = idx_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic                      full,
  output logic                      empty,
  output logic [ADDR_W:0]           count,
  output logic [ID_W-1:0]           grant_id
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W-1:0] r_ptr;
  logic [ID_W-1:0]   last_grant;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] wr_word;
  logic              wr_fire;
  logic              rd_fire;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign wr_fire = |req_ready;
  // No bypass: a pop needs an entry that was already stored last cycle.
  assign rd_fire = rd_en && !empty;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .enable     (!full),
    .gnt        (req_ready),
    .gnt_id     (grant_id)
  );

  // Select the winner's slice of the packed write data.
  always_comb begin
    wr_word = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) wr_word = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[w_ptr] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr      <= '0;
      r_ptr      <= '0;
      count      <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      rd_data    <= '0;
      rd_valid   <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (wr_fire) begin
        w_ptr      <= w_ptr + ADDR_W'(1);
        last_grant <= grant_id;
      end
      if (rd_fire) begin
        rd_data <= mem[r_ptr];
        r_ptr   <= r_ptr + ADDR_W'(1);
      end
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
